// File: rtl/icache_controller.sv
// Sequencing FSM for the icache: hit/miss lookup, line refill, flush and IF kill.
// Optional perf counters enabled by defining ICACHE_PERF_CNT_EN.
module icache_controller #(
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 if2icache_req_i,
  input  logic                 if2icache_kill_i,
  output logic                 icache2if_ack_o,
  input  logic                 flush_req_i,
  output logic                 flush_ack_o,
  input  logic                 cache_hit_i,
  output logic                 cache_rw_o,
  output logic                 icache_flush_o,
  output logic                 icache2mem_req_o,
  input  logic                 mem2icache_ack_i
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0] hit_cnt_o,
  output logic [CNT_WIDTH-1:0] miss_cnt_o
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    ALLOCATE,
    WRITE,
    FLUSH
  } state_t;

  state_t state;
  logic   kill_pend;

  if (CNT_WIDTH == 0) begin : g_width_check
    $error("icache_controller: CNT_WIDTH must be at least 1");
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state            <= IDLE;
      kill_pend        <= 1'b0;
      icache2if_ack_o  <= 1'b0;
      flush_ack_o      <= 1'b0;
      cache_rw_o       <= 1'b0;
      icache_flush_o   <= 1'b0;
      icache2mem_req_o <= 1'b0;
    end else begin
      icache2if_ack_o <= 1'b0;
      flush_ack_o     <= 1'b0;
      cache_rw_o      <= 1'b0;
      icache_flush_o  <= 1'b0;
      case (state)
        IDLE: begin
          // A level flush_req is still high while its ack shows; the ack cycle
          // likewise blocks re-accepting the request that was just served.
          if (flush_req_i && !flush_ack_o) begin
            state          <= FLUSH;
            icache_flush_o <= 1'b1;
          end else if (if2icache_req_i && !if2icache_kill_i && !icache2if_ack_o) begin
            state <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (if2icache_kill_i) begin
            state <= IDLE;
          end else if (cache_hit_i) begin
            state           <= IDLE;
            icache2if_ack_o <= 1'b1;
          end else begin
            state            <= ALLOCATE;
            icache2mem_req_o <= 1'b1;
          end
        end
        ALLOCATE: begin
          // The bus transfer cannot be aborted, so a kill is only remembered.
          if (mem2icache_ack_i) begin
            icache2mem_req_o <= 1'b0;
            kill_pend        <= 1'b0;
            if (kill_pend || if2icache_kill_i) begin
              state <= IDLE;
            end else begin
              state      <= WRITE;
              cache_rw_o <= 1'b1;
            end
          end else if (if2icache_kill_i) begin
            kill_pend <= 1'b1;
          end
        end
        WRITE: begin
          state <= if2icache_kill_i ? IDLE : LOOKUP;
        end
        FLUSH: begin
          state       <= IDLE;
          flush_ack_o <= 1'b1;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef ICACHE_PERF_CNT_EN
  // The LOOKUP that follows a refill is part of the miss, not a separate hit.
  logic refill;

  always_ff @(posedge clk_i) begin
    if (!rst_ni || state == FLUSH) begin
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
      refill     <= 1'b0;
    end else begin
      refill <= (state == WRITE);
      if (state == LOOKUP && !if2icache_kill_i) begin
        if (cache_hit_i && !refill && hit_cnt_o != '1) begin
          hit_cnt_o <= hit_cnt_o + 1'b1;
        end
        if (!cache_hit_i && miss_cnt_o != '1) begin
          miss_cnt_o <= miss_cnt_o + 1'b1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_icache_controller.sv
// Scoreboard bench for icache_controller: directed scenarios push expected
// (event, cycle) pairs; a negedge monitor pops and compares every strobe seen.
module tb_icache_controller;

  typedef enum logic [2:0] {EV_ACK, EV_FACK, EV_RW, EV_FLUSH, EV_MREQ} ev_t;
  typedef struct {
    ev_t kind;
    int  cyc;
  } exp_t;

  logic clk;
  logic rst_n;
  logic req, kill, ack;
  logic flush_req, flush_ack;
  logic cache_hit, cache_rw, icache_flush;
  logic mem_req, mem_ack;
`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;

  // Environment model state
  logic preset_hit = 1'b0;
  logic filled = 1'b0;
  logic mem_auto = 1'b1;
  int   mem_lat = 5;
  int   req_id = 0;
  int   stray_cycle = -1;

  icache_controller #(.CNT_WIDTH(32)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .if2icache_req_i  (req),
    .if2icache_kill_i (kill),
    .icache2if_ack_o  (ack),
    .flush_req_i      (flush_req),
    .flush_ack_o      (flush_ack),
    .cache_hit_i      (cache_hit),
    .cache_rw_o       (cache_rw),
    .icache_flush_o   (icache_flush),
    .icache2mem_req_o (mem_req),
    .mem2icache_ack_i (mem_ack)
`ifdef ICACHE_PERF_CNT_EN
    ,
    .hit_cnt_o        (hit_cnt),
    .miss_cnt_o       (miss_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  assign cache_hit = preset_hit | filled;

  // Datapath/memory model: line becomes valid on the write strobe, memory
  // answers after mem_lat cycles of request.
  initial begin
    int cnt;
    int last_id;
    cnt = 0;
    last_id = 0;
    mem_ack = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (req_id != last_id) begin
        filled  = 1'b0;
        last_id = req_id;
      end
      if (cache_rw === 1'b1) filled = 1'b1;
      if (icache_flush === 1'b1) filled = 1'b0;
      if (mem_req === 1'b1) cnt++;
      else cnt = 0;
      mem_ack = mem_auto ? (mem_req === 1'b1 && cnt == mem_lat) : (cyc == stray_cycle);
    end
  end

  task automatic observe(input ev_t k);
    exp_t e;
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $display("FAIL unexpected_%s: got event at cycle %0d, required none", k.name(), cyc);
    end else begin
      e = sb.pop_front();
      if (e.kind != k || e.cyc != cyc) begin
        miscompares++;
        $display("FAIL event_%s: got %s at cycle %0d, required %s at cycle %0d",
                 e.kind.name(), k.name(), cyc, e.kind.name(), e.cyc);
      end
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (mem_req === 1'b1) observe(EV_MREQ);
    if (cache_rw === 1'b1) observe(EV_RW);
    if (icache_flush === 1'b1) observe(EV_FLUSH);
    if (ack === 1'b1) observe(EV_ACK);
    if (flush_ack === 1'b1) observe(EV_FACK);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req_v);
    vectors++;
    if (act !== req_v) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, act, req_v);
    end
  endtask

`ifdef ICACHE_PERF_CNT_EN
  task automatic check_cnt(input string name, input int h, input int m);
    check({name, "_hit_cnt"}, 64'(hit_cnt), 64'(h));
    check({name, "_miss_cnt"}, 64'(miss_cnt), 64'(m));
  endtask
`endif

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input ev_t k, input int c);
    exp_t e;
    e.kind = k;
    e.cyc  = c;
    sb.push_back(e);
  endtask

  // Miss whose LOOKUP sits at t0+lk: request for lat cycles, write, LOOKUP, ack.
  task automatic push_miss(input int t0, input int lk, input int lat);
    for (int i = 1; i <= lat; i++) push(EV_MREQ, t0 + lk + i);
    push(EV_RW, t0 + lk + lat + 1);
    push(EV_ACK, t0 + lk + lat + 3);
  endtask

  task automatic fetch_hit();
    int t;
    t = cyc;
    preset_hit = 1'b1;
    req_id++;
    req = 1'b1;
    push(EV_ACK, t + 2);
    step(3);
    req = 1'b0;
  endtask

  task automatic fetch_miss(input int lat);
    int t;
    t = cyc;
    preset_hit = 1'b0;
    mem_lat = lat;
    req_id++;
    req = 1'b1;
    push_miss(t, 1, lat);
    step(lat + 5);
    req = 1'b0;
  endtask

  initial begin
    int t;
    rst_n = 1'b0;
    req = 1'b0;
    kill = 1'b0;
    flush_req = 1'b0;
    step(3);
    rst_n = 1'b1;
    check("reset_outputs", 64'({ack, flush_ack, cache_rw, icache_flush, mem_req}), 64'd0);
`ifdef ICACHE_PERF_CNT_EN
    check_cnt("reset", 0, 0);
`endif

    // Hits and misses mixed
    fetch_hit();
    fetch_hit();
    fetch_miss(5);
    fetch_hit();
    fetch_miss(3);
`ifdef ICACHE_PERF_CNT_EN
    check_cnt("mix", 3, 2);
`endif

    // Flush alone clears the counters
    t = cyc;
    flush_req = 1'b1;
    push(EV_FLUSH, t + 1);
    push(EV_FACK, t + 2);
    step(2);
`ifdef ICACHE_PERF_CNT_EN
    check_cnt("flush", 0, 0);
`endif
    flush_req = 1'b0;
    step(1);

    // Flush and request together: flush first, then the (now missing) fetch
    t = cyc;
    preset_hit = 1'b0;
    mem_lat = 5;
    req_id++;
    flush_req = 1'b1;
    req = 1'b1;
    push(EV_FLUSH, t + 1);
    push(EV_FACK, t + 2);
    push_miss(t, 3, 5);
    step(2);
    flush_req = 1'b0;
    step(10);
    req = 1'b0;
`ifdef ICACHE_PERF_CNT_EN
    check_cnt("flush_req", 0, 1);
`endif

    // Kill during ALLOCATE: transfer completes, no write, no ack
    t = cyc;
    preset_hit = 1'b0;
    mem_lat = 5;
    req_id++;
    req = 1'b1;
    for (int i = 2; i <= 6; i++) push(EV_MREQ, t + i);
    step(3);
    kill = 1'b1;
    req = 1'b0;
    step(1);
    kill = 1'b0;
    step(4);
    fetch_miss(2);

    // Kill during LOOKUP: no ack, not counted as a hit
    preset_hit = 1'b1;
    req_id++;
    req = 1'b1;
    step(1);
    kill = 1'b1;
    req = 1'b0;
    step(1);
    kill = 1'b0;
    step(2);
`ifdef ICACHE_PERF_CNT_EN
    check_cnt("kill", 0, 3);
`endif

    // Kill during WRITE: write completes, then IDLE without ack
    t = cyc;
    preset_hit = 1'b0;
    mem_lat = 3;
    req_id++;
    req = 1'b1;
    for (int i = 2; i <= 4; i++) push(EV_MREQ, t + i);
    push(EV_RW, t + 5);
    step(5);
    kill = 1'b1;
    req = 1'b0;
    step(1);
    kill = 1'b0;
    step(3);
    fetch_hit();

    // Flush arriving mid-miss waits for the refill ack
    t = cyc;
    preset_hit = 1'b0;
    mem_lat = 5;
    req_id++;
    req = 1'b1;
    push_miss(t, 1, 5);
    push(EV_FLUSH, t + 10);
    push(EV_FACK, t + 11);
    step(3);
    flush_req = 1'b1;
    step(7);
    req = 1'b0;
    step(1);
    flush_req = 1'b0;
    step(1);
`ifdef ICACHE_PERF_CNT_EN
    check_cnt("flush_miss", 0, 0);
`endif

    // Reset mid-miss, then a stray memory ack
    t = cyc;
    preset_hit = 1'b0;
    mem_auto = 1'b0;
    req_id++;
    req = 1'b1;
    for (int i = 2; i <= 4; i++) push(EV_MREQ, t + i);
    step(4);
    rst_n = 1'b0;
    req = 1'b0;
    step(1);
    rst_n = 1'b1;
    check("midreset_outputs", 64'({ack, flush_ack, cache_rw, icache_flush, mem_req}), 64'd0);
    stray_cycle = t + 6;
    step(4);
    mem_auto = 1'b1;
    fetch_hit();
`ifdef ICACHE_PERF_CNT_EN
    check_cnt("after_reset", 1, 0);
`endif

    step(3);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
